// File: rtl/led_pkg.sv
// Shared types and LED colour helpers for the LED colour arbiter.
package led_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // LED drive pairs, ordered {red, blue}
    localparam logic [1:0] LED_OFF  = 2'b00;
    localparam logic [1:0] LED_RED  = 2'b10;
    localparam logic [1:0] LED_BLUE = 2'b01;
    localparam logic [1:0] LED_BOTH = 2'b11;

    // Standard 2-bit colour code to {red, blue} drive
    function automatic logic [1:0] map_color(input logic [1:0] code);
        logic [1:0] drive;
        case (code)
            2'b00:   drive = LED_OFF;
            2'b01:   drive = LED_RED;
            2'b10:   drive = LED_BLUE;
            default: drive = LED_BOTH;
        endcase
        return drive;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: one-cycle tick every TICK_DIV cycles while clr is low.
// clr holds the count at zero so the first tick lands TICK_DIV cycles after clr falls.
module tick_prescaler #(
    parameter int TICK_DIV = 125_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    // Count 0..TICK_DIV-1, restarting on clear or on the tick itself
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = !clr && (r_cnt == LAST);

endmodule

// File: rtl/led_color_arbiter.sv
// Round-robin arbiter sharing the two bicolour LEDs between NREQ requesters.
// Each grant lasts DWELL_TICKS ticks or until its request drops, then one
// RELEASE cycle hands the pointer to the next index.
// Optional build macro LED_BLINK_EN: LEDs blink with a BLINK_TICKS half-period
// during a grant (colour_out itself never blinks).
module led_color_arbiter
    import led_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int TICK_DIV    = 125_000,
    parameter int DWELL_TICKS = 1000,
    parameter int BLINK_TICKS = 250
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [4*NREQ-1:0]   color_in,
    output logic [NREQ-1:0]     grant,
    output logic                done,
    output logic [3:0]          color_out,
    output logic                red1,
    output logic                blue1,
    output logic                red2,
    output logic                blue2
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int DWW  = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX   = IDXW'(NREQ - 1);
    localparam logic [DWW-1:0]  LAST_DWELL = DWW'(DWELL_TICKS - 1);

    if (NREQ < 2 || NREQ > 8 || TICK_DIV < 1 || DWELL_TICKS < 1 || BLINK_TICKS < 1) begin : g_param_check
        $error("led_color_arbiter: parameter out of range");
    end

    state_t          r_state, w_state_nxt;
    logic [IDXW-1:0] r_idx, r_rr_ptr, w_pick;
    logic            w_any;
    logic [DWW-1:0]  r_dwell;
    logic [NREQ-1:0] r_grant;
    logic [3:0]      r_color;
    logic            r_red1, r_blue1, r_red2, r_blue2;
    logic            w_not_grant, w_tick, w_expire, w_done, w_led_on;

    assign w_not_grant = (r_state != GRANT);

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_not_grant),
        .tick (w_tick)
    );

    assign w_expire = w_tick && (r_dwell == LAST_DWELL);

    // Round-robin pick: first asserted request at or above rr_ptr, wrapping
    always_comb begin
        int j;
        w_any  = 1'b0;
        w_pick = '0;
        j      = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            j = int'(r_rr_ptr) + i;
            if (j >= NREQ) j = j - NREQ;
            if (req[j[IDXW-1:0]]) begin
                w_any  = 1'b1;
                w_pick = j[IDXW-1:0];
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state and done pulse; expiry takes priority over a dropped request
    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        case (r_state)
            IDLE:    if (w_any) w_state_nxt = GRANT;
            GRANT: begin
                if (w_expire) begin
                    w_done      = 1'b1;
                    w_state_nxt = RELEASE;
                end else if (!req[r_idx]) begin
                    w_state_nxt = RELEASE;
                end
            end
            RELEASE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Grant, latched colour, dwell counter and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant  <= '0;
            r_color  <= '0;
            r_idx    <= '0;
            r_rr_ptr <= '0;
            r_dwell  <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_any) begin
                    r_grant <= NREQ'(1) << w_pick;
                    r_color <= color_in[{w_pick, 2'b00} +: 4];
                    r_idx   <= w_pick;
                    r_dwell <= '0;
                end
                GRANT: begin
                    if (w_tick) r_dwell <= r_dwell + 1'b1;
                    if (w_state_nxt == RELEASE) begin
                        r_grant <= '0;
                        r_color <= '0;
                    end
                end
                RELEASE: r_rr_ptr <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
                default: ;
            endcase
        end
    end

`ifdef LED_BLINK_EN
    logic w_blink_tick, r_blink_off;

    tick_prescaler #(.TICK_DIV(TICK_DIV * BLINK_TICKS)) u_blink (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_not_grant),
        .tick (w_blink_tick)
    );

    // Blink phase: starts lit at each new grant, flips every half-period
    always_ff @(posedge clk or posedge rst) begin
        if (rst)               r_blink_off <= 1'b0;
        else if (w_not_grant)  r_blink_off <= 1'b0;
        else if (w_blink_tick) r_blink_off <= ~r_blink_off;
    end

    assign w_led_on = ~r_blink_off;
`else
    assign w_led_on = 1'b1;
`endif

    // LED pins follow the latched colour one cycle later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {r_red1, r_blue1} <= LED_OFF;
            {r_red2, r_blue2} <= LED_OFF;
        end else begin
            {r_red1, r_blue1} <= map_color(r_color[3:2]) & {2{w_led_on}};
            {r_red2, r_blue2} <= map_color(r_color[1:0]) & {2{w_led_on}};
        end
    end

    assign grant     = r_grant;
    assign done      = w_done;
    assign color_out = r_color;
    assign red1      = r_red1;
    assign blue1     = r_blue1;
    assign red2      = r_red2;
    assign blue2     = r_blue2;

endmodule

// File: tb/tb_led_color_arbiter.sv
// Self-checking bench for led_color_arbiter with a small timing configuration.
module tb_led_color_arbiter;

    localparam int NREQ        = 4;
    localparam int TICK_DIV    = 4;
    localparam int DWELL_TICKS = 3;
    localparam int BLINK_TICKS = 1;
    localparam int LIMIT       = TICK_DIV * DWELL_TICKS;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [4*NREQ-1:0] color_in = 16'h96A3;
    logic [NREQ-1:0]   grant;
    logic              done;
    logic [3:0]        color_out;
    logic              red1, blue1, red2, blue2;

    led_color_arbiter #(
        .NREQ(NREQ), .TICK_DIV(TICK_DIV), .DWELL_TICKS(DWELL_TICKS), .BLINK_TICKS(BLINK_TICKS)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .color_in(color_in),
        .grant(grant), .done(done), .color_out(color_out),
        .red1(red1), .blue1(blue1), .red2(red2), .blue2(blue2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: who holds the grant, for how many cycles so far,
    // and what colour was visible last cycle (for the LED lag).
    int         m_cur = -1;
    int         m_age = 0;
    int         m_rr = 0;
    bit         m_rel = 1'b0;
    logic [3:0] m_col = 4'h0;
    logic [3:0] m_prev_col = 4'h0;
    bit         m_prev_on = 1'b1;

    always @(posedge clk or posedge rst) begin
        int k;
        if (rst) begin
            m_cur = -1; m_age = 0; m_rr = 0; m_rel = 1'b0;
            m_col = 4'h0; m_prev_col = 4'h0; m_prev_on = 1'b1;
        end else begin
            m_prev_col = (m_cur >= 0) ? m_col : 4'h0;
            m_prev_on  = (m_cur < 0) || ((((m_age - 1) / (TICK_DIV * BLINK_TICKS)) % 2) == 0);
            if (m_cur >= 0) begin
                if (m_age == LIMIT || !req[m_cur]) begin
                    m_rr  = (m_cur + 1) % NREQ;
                    m_cur = -1;
                    m_rel = 1'b1;
                end else begin
                    m_age++;
                end
            end else if (m_rel) begin
                m_rel = 1'b0;
            end else begin
                for (int i = 0; i < NREQ; i++) begin
                    k = (m_rr + i) % NREQ;
                    if (m_cur < 0 && req[k]) begin
                        m_cur = k;
                        m_age = 1;
                        m_col = color_in[4*k +: 4];
                    end
                end
            end
        end
    end

    logic [3:0] e_grant, e_col, e_led;
    logic       e_done;

    always @(negedge clk) begin
        if (!rst) begin
            e_grant = (m_cur >= 0) ? 4'(1 << m_cur) : 4'h0;
            e_col   = (m_cur >= 0) ? m_col : 4'h0;
            e_done  = (m_cur >= 0) && (m_age == LIMIT);
            e_led   = {m_prev_col[2], m_prev_col[3], m_prev_col[0], m_prev_col[1]};
`ifdef LED_BLINK_EN
            if (!m_prev_on) e_led = 4'h0;
`endif
            chk("model_grant", 32'(grant), 32'(e_grant));
            chk("model_color", 32'(color_out), 32'(e_col));
            chk("model_done", 32'(done), 32'(e_done));
            chk("model_leds", 32'({red1, blue1, red2, blue2}), 32'(e_led));
        end
    end

    task automatic wait_grant(output int n);
        n = 0;
        while (grant == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (grant == '0) chk("grant_wait_timeout", 32'(n), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    int n, len, done_at;
    logic [3:0] rr_seq [4] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_grant", 32'(grant), 32'(0));
        chk("reset_color", 32'(color_out), 32'(0));
        chk("reset_done", 32'(done), 32'(0));
        chk("reset_leds", 32'({red1, blue1, red2, blue2}), 32'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("idle_grant", 32'(grant), 32'(0));

        // Single persistent requester, colour 6
        req = 4'b0100;
        wait_grant(n);
        chk("single_latency", 32'(n), 32'(1));
        chk("single_grant", 32'(grant), 32'(4'b0100));
        chk("single_color", 32'(color_out), 32'(6));
        len = 0; done_at = 0;
        do begin
            len++;
            if (done) done_at = len;
            if (len == 2) chk("single_leds", 32'({red1, blue1, red2, blue2}), 32'(4'b1001));
            @(negedge clk);
        end while (grant == 4'b0100 && len < 50);
        chk("single_len", 32'(len), 32'(12));
        chk("single_done_at", 32'(done_at), 32'(12));
        wait_grant(n);
        chk("regrant_gap", 32'(n), 32'(2));
        chk("regrant_grant", 32'(grant), 32'(4'b0100));

        // Asynchronous reset in the middle of a grant
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_grant", 32'(grant), 32'(0));
        chk("midrst_color", 32'(color_out), 32'(0));
        chk("midrst_done", 32'(done), 32'(0));
        chk("midrst_leds", 32'({red1, blue1, red2, blue2}), 32'(0));
        req = 4'b0101;
        @(negedge clk);
        rst = 1'b0;
        wait_grant(n);
        chk("postrst_grant", 32'(grant), 32'(4'b0001));

        // Round-robin over requesters 0, 1, 3
        req = 4'b1011;
        for (int g = 0; g < 4; g++) begin
            if (g > 0) begin
                wait_grant(n);
                chk("rr_gap", 32'(n), 32'(2));
            end
            chk("rr_grant", 32'(grant), 32'(rr_seq[g]));
            len = 0; done_at = 0;
            do begin
                len++;
                if (done) done_at = len;
                @(negedge clk);
            end while (grant == rr_seq[g] && len < 50);
            chk("rr_len", 32'(len), 32'(12));
            chk("rr_done_at", 32'(done_at), 32'(12));
        end

        // Early drop of requester 1 on its fifth grant cycle
        wait_grant(n);
        chk("drop_grant", 32'(grant), 32'(4'b0010));
        len = 0; done_at = 0;
        do begin
            len++;
            if (done) done_at = len;
            if (len == 5) req = 4'b1001;
            @(negedge clk);
        end while (grant == 4'b0010 && len < 50);
        chk("drop_len", 32'(len), 32'(5));
        chk("drop_no_done", 32'(done_at), 32'(0));
        chk("drop_color_cleared", 32'(color_out), 32'(0));
        chk("drop_leds_lag", 32'({red1, blue1, red2, blue2}), 32'(4'b0101));
        @(negedge clk);
        chk("drop_leds_off", 32'({red1, blue1, red2, blue2}), 32'(0));

        // Request 3 drops on the expiry cycle; colour change mid-grant ignored
        wait_grant(n);
        chk("simul_grant", 32'(grant), 32'(4'b1000));
        len = 0; done_at = 0;
        do begin
            len++;
            if (len == 3) color_in[15:12] = 4'hF;
            if (len == 6) chk("simul_color_latched", 32'(color_out), 32'(9));
            if (len == 12) begin
                req = 4'b0001;
                #1;
                chk("simul_done", 32'(done), 32'(1));
            end
            if (done) done_at = len;
            @(negedge clk);
        end while (grant == 4'b1000 && len < 50);
        chk("simul_len", 32'(len), 32'(12));
        chk("simul_done_at", 32'(done_at), 32'(12));

        req = 4'b0000;
        repeat (20) @(negedge clk);
        chk("final_idle", 32'(grant), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
